// File: rtl/spram_arb_pkg.sv
// ============================================================================
// Module   : spram_arb_pkg
// Purpose  : Shared constants, types and the round-robin pick function for
//            the single-port RAM arbiter.
// Contents : DW, AW       - RAM data / address width (16x8 RAM)
//            MAX_REQ      - largest supported requester count
//            req_vec_t    - request/grant vector sized for MAX_REQ
//            req_idx_t    - requester index / pointer type
//            rr_pick()    - one-hot round-robin pick starting at a pointer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spram_arb_pkg;

  localparam int DW      = 8;
  localparam int AW      = 4;
  localparam int MAX_REQ = 8;

  typedef logic [MAX_REQ-1:0]         req_vec_t;
  typedef logic [$clog2(MAX_REQ)-1:0] req_idx_t;

  // Scan starting at ptr and return the first set request as a one-hot
  // vector. The index wraps at MAX_REQ; callers zero the bits above their
  // own requester count, so the effective wrap is at their count.
  function automatic req_vec_t rr_pick(input req_vec_t req, input req_idx_t ptr);
    req_vec_t gnt;
    req_idx_t idx;
    logic     found;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = ptr + req_idx_t'(i);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick_onehot.sv
// ============================================================================
// Module   : rr_pick_onehot
// Purpose  : Combinational round-robin picker: rotate the request vector to
//            the pointer, priority-encode, rotate back to a one-hot grant.
// Ports    : req  in  NUM_REQ  request vector
//            ptr  in  PTR_W    index with highest priority this cycle
//            gnt  out NUM_REQ  one-hot grant, or all zero when req is zero
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick_onehot
  import spram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  req_vec_t req_ext;
  req_vec_t gnt_ext;

  // Upper request bits are zero, so wrapping at MAX_REQ inside rr_pick
  // behaves exactly like wrapping at NUM_REQ.
  assign req_ext = req_vec_t'(req);
  assign gnt_ext = rr_pick(req_ext, req_idx_t'(ptr));
  assign gnt     = gnt_ext[NUM_REQ-1:0];

  generate
    if (NUM_REQ < MAX_REQ) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^gnt_ext[MAX_REQ-1:NUM_REQ];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/spram_arbiter.sv
// ============================================================================
// Module   : spram_arbiter
// Purpose  : Round-robin arbiter sharing one 16x8 single-port RAM between
//            NUM_REQ requesters. At most one access is granted per cycle;
//            read data returns one cycle after the grant to its issuer.
// Ports    : clk        in   1           clock, rising edge
//            reset      in   1           synchronous active-high reset
//            req        in   NUM_REQ     per-requester access request
//            req_we     in   NUM_REQ     1=write, 0=read
//            req_addr   in   NUM_REQ*AW  requester i at [i*AW +: AW]
//            req_wdata  in   NUM_REQ*DW  requester i at [i*DW +: DW]
//            gnt        out  NUM_REQ     one-hot grant, same cycle as req
//            rvalid     out  NUM_REQ     one-hot read-data-valid pulse
//            rdata      out  DW          read data (0 outside rvalid)
//            ram_en     out  1           RAM enable: 1=write, 0=read
//            ram_addr   out  AW          RAM address
//            ram_wdata  out  DW          RAM write data
//            ram_rdata  in   DW          RAM read data
// Options  : SPRAM_ARB_BURST_EN - when defined, a granted requester keeps
//            priority for up to BURST_LEN consecutive grants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int DW        = spram_arb_pkg::DW,
  parameter int AW        = spram_arb_pkg::AW,
  parameter int BURST_LEN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    rvalid,
  output logic [DW-1:0]         rdata,
  output logic                  ram_en,
  output logic [AW-1:0]         ram_addr,
  output logic [DW-1:0]         ram_wdata,
  input  logic [DW-1:0]         ram_rdata
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_ptr_nxt;
  logic [NUM_REQ-1:0] pick;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   idx_inc;
  logic               gnt_any;
  logic               rd_pending;
  logic [PTR_W-1:0]   rd_owner;
  logic               rd_live;

  rr_pick_onehot #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .gnt (pick)
  );

  assign gnt = reset ? '0 : pick;

  // Encode the one-hot grant back to an index.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_idx = PTR_W'(i);
    end
  end

  assign gnt_any = |gnt;
  assign idx_inc = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

  // RAM drive: granted requester's fields, otherwise all zero (the idle
  // read of address 0 is never returned to anyone).
  always_comb begin
    ram_en    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        ram_en    = req_we[i];
        ram_addr  = req_addr[i*AW +: AW];
        ram_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

`ifdef SPRAM_ARB_BURST_EN
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN + 1) : 1;

  // burst_cnt counts grants already given to the requester at rr_ptr in
  // the current burst; rr_ptr stays on that requester until the limit.
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_cnt_nxt;

  always_comb begin
    int n;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    n             = 1;
    if (gnt_any) begin
      // A grant to anyone other than the pointer owner starts a new burst.
      n = (gnt_idx == rr_ptr) ? int'(burst_cnt) + 1 : 1;
      if (n >= BURST_LEN) begin
        rr_ptr_nxt    = idx_inc;
        burst_cnt_nxt = '0;
      end else begin
        rr_ptr_nxt    = gnt_idx;
        burst_cnt_nxt = CNT_W'(n);
      end
    end else if (!req[rr_ptr]) begin
      // Owner dropped its request: the burst is over.
      burst_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) burst_cnt <= '0;
    else       burst_cnt <= burst_cnt_nxt;
  end
`else
  localparam int unused_burst_len = BURST_LEN;

  assign rr_ptr_nxt = gnt_any ? idx_inc : rr_ptr;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      rd_pending <= 1'b0;
      rd_owner   <= '0;
    end else begin
      rr_ptr     <= rr_ptr_nxt;
      rd_pending <= gnt_any & ~ram_en;
      rd_owner   <= gnt_idx;
    end
  end

  // Gating with reset drops a read that was granted just before reset.
  assign rd_live = rd_pending & ~reset;

  always_comb begin
    rvalid = '0;
    if (rd_live) rvalid[rd_owner] = 1'b1;
  end

  assign rdata = rd_live ? ram_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_spram_arbiter.sv
// ============================================================================
// Module   : tb_spram_arbiter
// Purpose  : Self-checking bench for spram_arbiter with a behavioural 16x8
//            synchronous RAM, a shadow memory and a read-return scoreboard.
// Options  : SPRAM_ARB_BURST_EN - selects burst-mode grant expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spram_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int DW        = 8;
  localparam int AW        = 4;
  localparam int BURST_LEN = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [7:0]  rdata;
  logic        ram_en;
  logic [3:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  always #5 clk = ~clk;

  spram_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DW        (DW),
    .AW        (AW),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Behavioural RAM: write on enable, registered read otherwise.
  logic [7:0] mem [16];
  logic       mem_init;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
    end else if (ram_en) begin
      mem[ram_addr] <= ram_wdata;
    end else begin
      ram_rdata <= mem[ram_addr];
    end
  end

  logic [7:0] shadow [16];

  int cyc         = 0;
  int vectors     = 0;
  int miscompares = 0;
  logic mon_en    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [1:0] owner;
    logic [7:0] data;
  } rd_exp_t;

  rd_exp_t sb [$];
  rd_exp_t mon_e;

  // Read-return monitor: every cycle either an expected return is due or
  // rvalid must be quiet.
  always @(negedge clk) begin
    if (mon_en) begin
      vectors++;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        if (rvalid !== mon_e.owner || rdata !== mon_e.data) begin
          miscompares++;
          $display("FAIL rd_return cyc=%0d: rvalid=%b rdata=%h, required rvalid=%b rdata=%h",
                   cyc, rvalid, rdata, mon_e.owner, mon_e.data);
        end
      end else if (rvalid !== 2'b00) begin
        miscompares++;
        $display("FAIL spurious_rvalid cyc=%0d: rvalid=%b, required 00", cyc, rvalid);
      end
    end
  end

  // Called at the negedge of the grant cycle; data returns next cycle.
  task automatic push_rd(input logic [1:0] owner, input logic [3:0] addr);
    rd_exp_t e;
    e.due   = cyc + 1;
    e.owner = owner;
    e.data  = shadow[addr];
    sb.push_back(e);
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] we,
                       input logic [3:0] a0, input logic [3:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    @(posedge clk);
    #1;
    req       = r;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  task automatic test_reset;
    drive(2'b11, 2'b00, 4'd5, 4'd6, 8'h11, 8'h22);
    @(negedge clk);
    vectors++;
    if (gnt !== 2'b00) begin
      miscompares++; $display("FAIL reset_gnt: gnt=%b, required 00", gnt);
    end
    vectors++;
    if (ram_en !== 1'b0 || ram_addr !== 4'd0 || ram_wdata !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_ram: en=%b addr=%h wdata=%h, required 0 0 0", ram_en, ram_addr, ram_wdata);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (gnt !== 2'b01 || ram_addr !== 4'd5 || ram_en !== 1'b0) begin
      miscompares++;
      $display("FAIL first_gnt: gnt=%b addr=%h en=%b, required 01 5 0", gnt, ram_addr, ram_en);
    end
    push_rd(2'b01, 4'd5);
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
    vectors++;
    if (gnt !== 2'b00) begin
      miscompares++; $display("FAIL idle_after_reset: gnt=%b, required 00", gnt);
    end
  endtask

  task automatic test_write_read;
    drive(2'b01, 2'b01, 4'd3, 4'd0, 8'hA5, 8'h00);
    @(negedge clk);
    vectors++;
    if (gnt !== 2'b01 || ram_en !== 1'b1 || ram_addr !== 4'd3 || ram_wdata !== 8'hA5) begin
      miscompares++;
      $display("FAIL write_drive: gnt=%b en=%b addr=%h wdata=%h, required 01 1 3 a5",
               gnt, ram_en, ram_addr, ram_wdata);
    end
    shadow[3] = 8'hA5;
    drive(2'b10, 2'b00, 4'd0, 4'd3, 8'h00, 8'h00);
    @(negedge clk);
    vectors++;
    if (gnt !== 2'b10 || ram_en !== 1'b0 || ram_addr !== 4'd3) begin
      miscompares++;
      $display("FAIL read_after_write: gnt=%b en=%b addr=%h, required 10 0 3", gnt, ram_en, ram_addr);
    end
    push_rd(2'b10, 4'd3);
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_seq [8];
`ifdef SPRAM_ARB_BURST_EN
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
`else
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00);
      @(negedge clk);
      vectors++;
      if (gnt !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL b2b_gnt[%0d]: gnt=%b, required %b", i, gnt, exp_seq[i]);
      end
      push_rd(exp_seq[i], (exp_seq[i] == 2'b01) ? 4'd1 : 4'd2);
    end
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_reset_drop;
    drive(2'b01, 2'b00, 4'd7, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
    vectors++;
    if (gnt !== 2'b01) begin
      miscompares++; $display("FAIL drop_gnt: gnt=%b, required 01", gnt);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    req   = 2'b00;
    @(negedge clk);
    vectors++;
    if (rvalid !== 2'b00) begin
      miscompares++; $display("FAIL drop_rvalid: rvalid=%b, required 00", rvalid);
    end
    @(posedge clk);
    #1;
    reset    = 1'b0;
    req      = 2'b11;
    req_we   = 2'b00;
    req_addr = {4'd8, 4'd4};
    @(negedge clk);
    vectors++;
    if (gnt !== 2'b01) begin
      miscompares++; $display("FAIL ptr_after_reset: gnt=%b, required 01", gnt);
    end
    push_rd(2'b01, 4'd4);
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_idle;
    logic [1:0] exp_g;
`ifdef SPRAM_ARB_BURST_EN
    exp_g = 2'b01;
`else
    exp_g = 2'b10;
`endif
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 2'b11, 4'd9, 4'd10, 8'h55, 8'h66);
      @(negedge clk);
      vectors++;
      if (gnt !== 2'b00 || ram_en !== 1'b0 || ram_addr !== 4'd0 || ram_wdata !== 8'd0) begin
        miscompares++;
        $display("FAIL idle[%0d]: gnt=%b en=%b addr=%h wdata=%h, required 00 0 0 0",
                 i, gnt, ram_en, ram_addr, ram_wdata);
      end
    end
    drive(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00);
    @(negedge clk);
    vectors++;
    if (gnt !== exp_g) begin
      miscompares++; $display("FAIL ptr_held_idle: gnt=%b, required %b", gnt, exp_g);
    end
    push_rd(exp_g, (exp_g == 2'b01) ? 4'd1 : 4'd2);
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_mixed;
    drive(2'b11, 2'b01, 4'd9, 4'd9, 8'h3C, 8'h00);
    @(negedge clk);
    vectors++;
    if (gnt !== 2'b01 || ram_en !== 1'b1 || ram_wdata !== 8'h3C) begin
      miscompares++;
      $display("FAIL mixed_write: gnt=%b en=%b wdata=%h, required 01 1 3c", gnt, ram_en, ram_wdata);
    end
    shadow[9] = 8'h3C;
    drive(2'b10, 2'b00, 4'd9, 4'd9, 8'h00, 8'h00);
    @(negedge clk);
    vectors++;
    if (gnt !== 2'b10) begin
      miscompares++; $display("FAIL mixed_loser: gnt=%b, required 10", gnt);
    end
    push_rd(2'b10, 4'd9);
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    mem_init  = 1'b1;
    req       = 2'b00;
    req_we    = 2'b00;
    req_addr  = 8'h00;
    req_wdata = 16'h0000;
    for (int i = 0; i < 16; i++) shadow[i] = 8'h10 + 8'(i);
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    mon_en   = 1'b1;

    test_reset;
    test_write_read;
    test_back_to_back;
    test_reset_drop;
    test_idle;
    test_mixed;

    repeat (3) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: %0d reads outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
